// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   XLEN / REG_ADDR_W : write data and register address widths
//   REG_ZERO          : address of the hard-wired zero register (writes dropped)
//   wb_req_t          : one pending writeback {addr, data}
//   req_id_t          : requester index (ALU = 0, load unit = 1)
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the
// register file write port.
//   master : requester / register-file side (drives reqN_valid/rdAdrs/rdData)
//   slave  : arbiter side (drives reqN_ready, enable, rdAdrs, rdData, grant_id, busy)
// With REGFILE_WB_ARB_FWD_EN defined the bundle also carries the rs1/rs2
// forwarding lookup signals.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_rdAdrs;
    logic [XLEN-1:0]       req0_rdData;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_rdAdrs;
    logic [XLEN-1:0]       req1_rdData;

    logic                  enable;
    logic [REG_ADDR_W-1:0] rdAdrs;
    logic [XLEN-1:0]       rdData;
    logic                  grant_id;
    logic                  busy;

`ifdef REGFILE_WB_ARB_FWD_EN
    logic [REG_ADDR_W-1:0] rs1Adrs;
    logic [REG_ADDR_W-1:0] rs2Adrs;
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic [XLEN-1:0]       rs2_fwd_data;
`endif

    modport master (
        output req0_valid, req0_rdAdrs, req0_rdData,
        output req1_valid, req1_rdAdrs, req1_rdData,
        input  req0_ready, req1_ready,
        input  enable, rdAdrs, rdData, grant_id, busy
`ifdef REGFILE_WB_ARB_FWD_EN
        , output rs1Adrs, rs2Adrs
        , input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

    modport slave (
        input  req0_valid, req0_rdAdrs, req0_rdData,
        input  req1_valid, req1_rdAdrs, req1_rdData,
        output req0_ready, req1_ready,
        output enable, rdAdrs, rdData, grant_id, busy
`ifdef REGFILE_WB_ARB_FWD_EN
        , input  rs1Adrs, rs2Adrs
        , output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback hold slot.
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   i_push         : handshake transfer this cycle (valid && ready)
//   i_req          : offered {addr, data}
//   i_clear        : slot is granted this cycle
//   o_valid/o_req  : held entry
//   o_load         : slot captures i_req at this edge (x0 pushes never load)
module wb_hold_slot
    import regfile_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    input  logic    i_push,
    input  wb_req_t i_req,
    input  logic    i_clear,
    output logic    o_valid,
    output wb_req_t o_req,
    output logic    o_load
);

    logic    r_valid;
    wb_req_t r_req;
    logic    w_load;

    assign w_load = i_push && (i_req.addr != REG_ZERO);

    // A load in the same cycle as a clear refills the slot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_req   <= i_req;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;
    assign o_load  = w_load;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (req0) and
// the load unit (req1). Each requester owns a one-entry hold slot; the
// older slot wins, same-edge ties go to a round-robin pointer, and x0
// writes are accepted but discarded.
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   wb (slave)     : requester handshakes, write port enable/rdAdrs/rdData,
//                    grant_id, busy
// Optional: REGFILE_WB_ARB_FWD_EN adds rs1/rs2 forwarding of the write that
// is in flight to register_file.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  wb
);

    logic    w_v0, w_v1, w_load0, w_load1, w_push0, w_push1;
    logic    w_rdy0, w_rdy1, w_clr0, w_clr1;
    logic    w_gnt_vld, w_tie, w_v0_nxt, w_v1_nxt;
    wb_req_t w_in0, w_in1, w_q0, w_q1, w_gnt_req;
    req_id_t w_gnt_id;

    logic                  r_age_vld;
    req_id_t               r_age_old;
    req_id_t               r_rr;
    logic                  r_enable;
    logic [REG_ADDR_W-1:0] r_rdAdrs;
    logic [XLEN-1:0]       r_rdData;
    req_id_t               r_grant_id;

    assign w_in0   = '{addr: wb.req0_rdAdrs, data: wb.req0_rdData};
    assign w_in1   = '{addr: wb.req1_rdAdrs, data: wb.req1_rdData};
    assign w_push0 = wb.req0_valid && w_rdy0;
    assign w_push1 = wb.req1_valid && w_rdy1;

    wb_hold_slot u_slot0 (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push0),
        .i_req   (w_in0),
        .i_clear (w_clr0),
        .o_valid (w_v0),
        .o_req   (w_q0),
        .o_load  (w_load0)
    );

    wb_hold_slot u_slot1 (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push1),
        .i_req   (w_in1),
        .i_clear (w_clr1),
        .o_valid (w_v1),
        .o_req   (w_q1),
        .o_load  (w_load1)
    );

    always_comb begin
        w_gnt_vld = w_v0 || w_v1;
        w_tie     = w_v0 && w_v1 && !r_age_vld;
        w_gnt_id  = REQ_ALU;
        if (w_v0 && w_v1) begin
            w_gnt_id = r_age_vld ? r_age_old : r_rr;
        end else if (w_v1) begin
            w_gnt_id = REQ_LOAD;
        end
        w_clr0    = w_gnt_vld && (w_gnt_id == REQ_ALU);
        w_clr1    = w_gnt_vld && (w_gnt_id == REQ_LOAD);
        w_gnt_req = (w_gnt_id == REQ_LOAD) ? w_q1 : w_q0;
    end

    // Ready comes from slot state only, never from reqN_valid.
    assign w_rdy0 = !w_v0 || w_clr0;
    assign w_rdy1 = !w_v1 || w_clr1;

    assign w_v0_nxt = w_load0 || (w_v0 && !w_clr0);
    assign w_v1_nxt = w_load1 || (w_v1 && !w_clr1);

    // The age flag only has meaning while both slots end up valid; the slot
    // that did not load at this edge is the older one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_age_vld  <= 1'b0;
            r_age_old  <= REQ_ALU;
            r_rr       <= REQ_ALU;
            r_enable   <= 1'b0;
            r_rdAdrs   <= '0;
            r_rdData   <= '0;
            r_grant_id <= REQ_ALU;
        end else begin
            if (w_v0_nxt && w_v1_nxt) begin
                if (w_load0 && !w_load1) begin
                    r_age_vld <= 1'b1;
                    r_age_old <= REQ_LOAD;
                end else if (w_load1 && !w_load0) begin
                    r_age_vld <= 1'b1;
                    r_age_old <= REQ_ALU;
                end else if (w_load0 && w_load1) begin
                    r_age_vld <= 1'b0;
                end
            end else begin
                r_age_vld <= 1'b0;
            end

            if (w_tie) begin
                r_rr <= (r_rr == REQ_ALU) ? REQ_LOAD : REQ_ALU;
            end

            r_enable <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rdAdrs   <= w_gnt_req.addr;
                r_rdData   <= w_gnt_req.data;
                r_grant_id <= w_gnt_id;
            end
        end
    end

    assign wb.req0_ready = w_rdy0;
    assign wb.req1_ready = w_rdy1;
    assign wb.enable     = r_enable;
    assign wb.rdAdrs     = r_rdAdrs;
    assign wb.rdData     = r_rdData;
    assign wb.grant_id   = r_grant_id;
    assign wb.busy       = w_v0 || w_v1 || r_enable;

`ifdef REGFILE_WB_ARB_FWD_EN
    assign wb.rs1_fwd_valid = r_enable && (r_rdAdrs == wb.rs1Adrs) && (wb.rs1Adrs != REG_ZERO);
    assign wb.rs2_fwd_valid = r_enable && (r_rdAdrs == wb.rs2Adrs) && (wb.rs2Adrs != REG_ZERO);
    assign wb.rs1_fwd_data  = r_rdData;
    assign wb.rs2_fwd_data  = r_rdData;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table for the
// multi-cycle corner cases, then randomized traffic against a timestamp-based
// reference model and a final register-file content comparison.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if wb();

    regfile_wb_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .wb      (wb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file image built from the DUT's write port.
    logic [31:0] tb_regs [32];
    logic        clr_regs = 1'b1;
    always @(posedge clock) begin
        if (clr_regs) begin
            for (int i = 0; i < 32; i++) tb_regs[i] <= '0;
        end else if (wb.enable) begin
            tb_regs[wb.rdAdrs] <= wb.rdData;
        end
    end

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        wb.req0_valid  = v0;
        wb.req0_rdAdrs = a0;
        wb.req0_rdData = d0;
        wb.req1_valid  = v1;
        wb.req1_rdAdrs = a1;
        wb.req1_rdData = d1;
    endtask

    typedef struct {
        int unsigned rst_n, v0, a0, d0, v1, a1, d1;
        int unsigned e_r0, e_r1, e_en, e_adr, e_dat, e_gid, e_busy;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    // Reference model: slots tagged with the edge number they were loaded on.
    logic        mv [2];
    logic [4:0]  ma [2];
    logic [31:0] md [2];
    int          ms [2];
    int          edge_no;
    logic        mrr, men, mgid;
    logic [4:0]  mao;
    logic [31:0] mdo;
    logic [31:0] golden [32];

    function automatic void model_grant(output logic gv, output logic g, output logic tie);
        gv  = mv[0] || mv[1];
        tie = 1'b0;
        g   = 1'b0;
        if (mv[0] && mv[1]) begin
            if (ms[0] < ms[1])      g = 1'b0;
            else if (ms[1] < ms[0]) g = 1'b1;
            else begin
                g   = mrr;
                tie = 1'b1;
            end
        end else begin
            g = mv[1];
        end
    endfunction

    logic        rv0, rv1, gv, g, tie, acc0, acc1;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;

    initial begin
        tbl[0]  = '{0, 1, 3, 55, 0, 0, 0,        1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 3, 55, 0, 0, 0,        1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 20, 0, 0, 0,        1, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 1, 20, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 1, 20, 0, 0};
        tbl[5]  = '{1, 1, 2, 286, 1, 4, 1024,    1, 0, 0, 1, 20, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 2, 286, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 4, 1024, 1, 1};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 4, 1024, 1, 0};
        tbl[9]  = '{1, 1, 2, 300, 1, 4, 400,     0, 1, 0, 4, 1024, 1, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 4, 400, 1, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 2, 300, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 2, 300, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 5, 7,         1, 1, 0, 2, 300, 0, 1};
        tbl[14] = '{1, 1, 5, 12, 0, 0, 0,        1, 1, 1, 5, 7, 1, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 5, 12, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 5, 12, 0, 0};
        tbl[17] = '{1, 1, 0, 99, 0, 0, 0,        1, 1, 0, 5, 12, 0, 0};
        tbl[18] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 5, 12, 0, 0};
        tbl[19] = '{1, 1, 10, 100, 1, 11, 200,   1, 0, 0, 5, 12, 0, 1};
        tbl[20] = '{1, 1, 12, 101, 0, 0, 0,      0, 1, 1, 10, 100, 0, 1};
        tbl[21] = '{1, 0, 0, 0, 1, 13, 201,      1, 0, 1, 11, 200, 1, 1};
        tbl[22] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 12, 101, 0, 1};
        tbl[23] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 1, 13, 201, 1, 1};
        tbl[24] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 13, 201, 1, 0};
        tbl[25] = '{1, 1, 14, 5, 0, 0, 0,        1, 1, 0, 13, 201, 1, 1};
        tbl[26] = '{0, 0, 0, 0, 0, 0, 0,         1, 1, 0, 0, 0, 0, 0};
        tbl[27] = '{1, 0, 0, 0, 0, 0, 0,         1, 1, 0, 0, 0, 0, 0};

`ifdef REGFILE_WB_ARB_FWD_EN
        wb.rs1Adrs = '0;
        wb.rs2Adrs = '0;
`endif
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Directed vectors: inputs set up before an edge, outputs checked 1 after it.
        for (int i = 0; i < NVEC; i++) begin
            reset_n = tbl[i].rst_n[0];
            drive(tbl[i].v0[0], 5'(tbl[i].a0), tbl[i].d0, tbl[i].v1[0], 5'(tbl[i].a1), tbl[i].d1);
            @(posedge clock);
            #1;
            clr_regs = 1'b0;
            check($sformatf("vec%0d.req0_ready", i), 32'(wb.req0_ready), tbl[i].e_r0);
            check($sformatf("vec%0d.req1_ready", i), 32'(wb.req1_ready), tbl[i].e_r1);
            check($sformatf("vec%0d.enable", i),     32'(wb.enable),     tbl[i].e_en);
            check($sformatf("vec%0d.rdAdrs", i),     32'(wb.rdAdrs),     tbl[i].e_adr);
            check($sformatf("vec%0d.rdData", i),     wb.rdData,          tbl[i].e_dat);
            check($sformatf("vec%0d.grant_id", i),   32'(wb.grant_id),   tbl[i].e_gid);
            check($sformatf("vec%0d.busy", i),       32'(wb.busy),       tbl[i].e_busy);
`ifdef REGFILE_WB_ARB_FWD_EN
            if (i == 15) begin
                wb.rs1Adrs = 5'd5;
                wb.rs2Adrs = 5'd6;
                #1;
                check("fwd.rs1_valid_hit", 32'(wb.rs1_fwd_valid), 32'd1);
                check("fwd.rs1_data",      wb.rs1_fwd_data,       32'd12);
                check("fwd.rs2_valid_miss", 32'(wb.rs2_fwd_valid), 32'd0);
                wb.rs1Adrs = 5'd0;
                #1;
                check("fwd.rs1_valid_x0",  32'(wb.rs1_fwd_valid), 32'd0);
            end
`endif
            @(negedge clock);
        end

        // Register contents written by the directed sequences.
        check("reg.x1",  tb_regs[1],  32'd20);
        check("reg.x2",  tb_regs[2],  32'd300);
        check("reg.x4",  tb_regs[4],  32'd400);
        check("reg.x5",  tb_regs[5],  32'd12);
        check("reg.x10", tb_regs[10], 32'd100);
        check("reg.x13", tb_regs[13], 32'd201);
        check("reg.x14_discarded", tb_regs[14], 32'd0);
        check("reg.x0_untouched",  tb_regs[0],  32'd0);

        // Idle cycle that also wipes the register image for the random phase.
        clr_regs = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clock);
        #1;
        clr_regs = 1'b0;

        for (int n = 0; n < 2; n++) begin
            mv[n] = 1'b0; ma[n] = '0; md[n] = '0; ms[n] = 0;
        end
        for (int r = 0; r < 32; r++) golden[r] = '0;
        edge_no = 0;
        mrr = 1'b0; men = 1'b0; mgid = 1'b0; mao = '0; mdo = '0;

        for (int c = 0; c < 404; c++) begin
            @(negedge clock);
            if (c < 400) begin
                rv0 = ($urandom_range(0, 3) != 0);
                rv1 = ($urandom_range(0, 3) != 0);
                ra0 = 5'($urandom_range(0, 31));
                ra1 = 5'($urandom_range(0, 31));
                rd0 = $urandom;
                rd1 = $urandom;
                if (rv0 && rv1 && ra0 == ra1) ra1 = ra0 + 5'd1;
            end else begin
                rv0 = 1'b0; rv1 = 1'b0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
            end
            drive(rv0, ra0, rd0, rv1, ra1, rd1);

            model_grant(gv, g, tie);
            acc0 = rv0 && (!mv[0] || (gv && g == 1'b0));
            acc1 = rv1 && (!mv[1] || (gv && g == 1'b1));
            @(posedge clock);
            if (gv) begin
                men  = 1'b1;
                mao  = ma[g];
                mdo  = md[g];
                mgid = g;
                mv[g] = 1'b0;
                if (tie) mrr = !mrr;
            end else begin
                men = 1'b0;
            end
            if (acc0 && ra0 != 5'd0) begin
                mv[0] = 1'b1; ma[0] = ra0; md[0] = rd0; ms[0] = edge_no;
                golden[ra0] = rd0;
            end
            if (acc1 && ra1 != 5'd0) begin
                mv[1] = 1'b1; ma[1] = ra1; md[1] = rd1; ms[1] = edge_no;
                golden[ra1] = rd1;
            end
            edge_no++;

            model_grant(gv, g, tie);
            #1;
            check($sformatf("rnd%0d.req0_ready", c), 32'(wb.req0_ready), 32'(!mv[0] || (gv && g == 1'b0)));
            check($sformatf("rnd%0d.req1_ready", c), 32'(wb.req1_ready), 32'(!mv[1] || (gv && g == 1'b1)));
            check($sformatf("rnd%0d.enable", c),     32'(wb.enable),     32'(men));
            check($sformatf("rnd%0d.rdAdrs", c),     32'(wb.rdAdrs),     32'(mao));
            check($sformatf("rnd%0d.rdData", c),     wb.rdData,          mdo);
            check($sformatf("rnd%0d.grant_id", c),   32'(wb.grant_id),   32'(mgid));
            check($sformatf("rnd%0d.busy", c),       32'(wb.busy),       32'(mv[0] || mv[1] || men));
        end

        // Final contents: last accepted value per address wins.
        @(posedge clock);
        #1;
        for (int r = 0; r < 32; r++) begin
            check($sformatf("final.x%0d", r), tb_regs[r], golden[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (enable, rdAdrs, rdData) between two writeback requesters: req0 (ALU) and req1 (load unit).
- Each requester has a one-entry hold slot with a valid/ready handshake.
- Arbitration is oldest-first, with round-robin to break ties; writes to x0 are dropped.
- Sits between the execute/memory writeback stages and register_file.

Parameters:
- XLEN, 32, data width of the register write data.
- REG_ADDR_W, 5, register address width (32 registers).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 slot can accept
- req0_rdAdrs  in  REG_ADDR_W  destination register, requester 0
- req0_rdData  in  XLEN  write data, requester 0
- req1_valid, req1_ready, req1_rdAdrs, req1_rdData  same as req0, for requester 1
- enable  out  1  write enable to register_file
- rdAdrs  out  REG_ADDR_W  write address to register_file
- rdData  out  XLEN  write data to register_file
- grant_id  out  1  requester that owns the current enable pulse
- busy  out  1  any hold slot valid or enable high

Behaviour:
- Reset (reset_n low at a clock edge): both slots empty, age flag cleared, round-robin pointer = 0, enable = 0, rdAdrs = 0, rdData = 0, grant_id = 0, busy = 0.
  - Reset mid-operation discards held requests without writing them.
- Handshake: a transfer happens on an edge where reqN_valid && reqN_ready.
  - reqN_ready = !slotN_valid || slotN_granted_this_cycle.
  - reqN_ready depends only on registered state, never on reqN_valid.
- x0 rule: a transfer with rdAdrs == 0 completes normally (ready honoured) but does not load the slot and never produces enable.
- Arbitration, evaluated combinationally from slot state each cycle; the grant takes effect at the next edge:
  - Neither slot valid: no grant; enable = 0 next cycle.
  - Exactly one slot valid: grant it.
  - Both valid, different load cycles: grant the older (age flag). The age flag is set when a slot loads while the other slot is already valid.
  - Both valid, loaded on the same edge: grant the requester indicated by the round-robin pointer. The pointer toggles after every tie-break grant.
- Grant at edge k: at edge k, enable <= 1, rdAdrs/rdData <= slot contents, grant_id <= index, and the slot clears. register_file writes at edge k+1.
- Latency: accept at edge k, slot valid after k, outputs driven after k+1, register written at k+2. Two cycles minimum.
- Throughput:
  - One write per cycle aggregate.
  - A single streaming requester sustains one per cycle (its slot refills as it is granted).
  - With both streaming, the requesters alternate.
- Same-address conflict: ordering follows acceptance order, so the later-accepted value is the final register content.
- enable drops to 0 in any cycle following an edge with no grant; rdAdrs/rdData hold their last values.
- busy = slot0_valid | slot1_valid | enable.

Optional Feature:
- Macro REGFILE_WB_ARB_FWD_EN.
- Defined: adds ports rs1Adrs, rs2Adrs (in, REG_ADDR_W) and rs1_fwd_valid, rs2_fwd_valid (out, 1), rs1_fwd_data, rs2_fwd_data (out, XLEN).
  - rsN_fwd_valid = enable && rdAdrs == rsNAdrs && rsNAdrs != 0 (combinational).
  - rsN_fwd_data = rdData.
  - Covers the write-in-flight cycle before register_file updates.
- Undefined: these ports and this logic do not exist.

Decomposition:
- Package regfile_pkg:
  - XLEN and REG_ADDR_W constants.
  - REG_ZERO = 5'd0.
  - typedef wb_req_t {addr, data}.
  - typedef req_id_t (1 bit).
- Sub-module wb_hold_slot, instantiated twice: one-entry register holding wb_req_t, with valid, load, clear and x0 filter.

Test Plan:
- Reset: hold reset_n = 0 for 2 edges with req0_valid = 1 -> enable = 0, busy = 0, req0_ready = 1, no write.
- Single write: req0 (x1, 20) accepted at edge 1 -> enable = 1, rdAdrs = 1, rdData = 20, grant_id = 0 after edge 2, and x1 reads 20 after edge 3.
- Simultaneous requests: req0 (x2, 286) and req1 (x4, 1024) accepted on the same edge -> two consecutive enable cycles, x2 first (pointer = 0); repeating the pattern grants req1 first.
- Age order and same address: req1 (x5, 7) accepted at edge 1, req0 (x5, 12) at edge 2 -> writes 7 then 12, and x5 ends at 12.
- x0 drop: req0 (x0, 99) -> req0_ready = 1, enable never asserted, busy stays 0.
- Forwarding, with REGFILE_WB_ARB_FWD_EN defined: rs1Adrs = 5 during the enable cycle writing (x5, 12) -> rs1_fwd_valid = 1, rs1_fwd_data = 12; rs1Adrs = 0 -> rs1_fwd_valid = 0.
